// File: rtl/acc_seq_pkg.sv
// Shared types and helpers for the accumulator FSM sequencer.
// Op codes, sequencer states and the mod-N step distance.
package acc_seq_pkg;

    typedef enum logic [1:0] {
        OP_CLEAR = 2'd0,
        OP_ADD   = 2'd1,
        OP_LOAD  = 2'd2,
        OP_READ  = 2'd3
    } op_e;

    typedef enum logic [2:0] {
        S_IDLE,
        S_STEP,
        S_DWELL,
        S_CAPTURE,
        S_RESP
    } seq_state_e;

    function automatic int unsigned op_target(op_e op);
        int unsigned t;
        t = 0;
        unique case (op)
            OP_CLEAR: t = 0;
            OP_ADD:   t = 1;
            OP_LOAD:  t = 2;
            default:  t = 0;
        endcase
        return t;
    endfunction

    // Forward distance from cur to tgt around a ring of n states.
    function automatic int unsigned steps_to(int unsigned cur,
                                             int unsigned tgt,
                                             int unsigned n);
        return (tgt + n - cur) % n;
    endfunction

endpackage

// File: rtl/acc_fsm_sequencer.sv
// Drives the three-state accumulator FSM from a request/response port.
// Mirrors the downstream mod-N state and steps it to each op's target.
module acc_fsm_sequencer
    import acc_seq_pkg::*;
#(
    parameter int unsigned WIDTH      = 16,
    parameter int unsigned NUM_STATES = 3,
    parameter int unsigned STEP_CODE  = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [1:0]       req_op,
    input  logic [WIDTH-1:0] req_data,
    output logic [WIDTH-1:0] signal,
    output logic             next,
    output logic [WIDTH-1:0] data_out,
    input  logic [WIDTH-1:0] signal_in,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [WIDTH-1:0] rsp_data
);

    localparam int unsigned MW = (NUM_STATES > 1) ? $clog2(NUM_STATES) : 1;

    seq_state_e       state_q, state_d;
    logic [MW-1:0]    mirror_q, mirror_d;
    logic [MW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic [WIDTH-1:0] rsp_q, rsp_d;
    logic             rdy_q, rdy_d;
    logic             accept;
    op_e              op;
    int unsigned      k;

    assign op     = op_e'(req_op);
    assign accept = req_valid & rdy_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_IDLE;
            mirror_q <= '0;
            cnt_q    <= '0;
            data_q   <= '0;
            rsp_q    <= '0;
            rdy_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            mirror_q <= mirror_d;
            cnt_q    <= cnt_d;
            data_q   <= data_d;
            rsp_q    <= rsp_d;
            rdy_q    <= rdy_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        mirror_d = mirror_q;
        cnt_d    = cnt_q;
        data_d   = data_q;
        rsp_d    = rsp_q;
        k        = 0;
        unique case (state_q)
            S_IDLE: begin
                if (accept) begin
                    data_d = req_data;
                    if (op == OP_READ) begin
                        state_d = S_CAPTURE;
                    end else begin
                        k = steps_to(int'(mirror_q), op_target(op),
                                     NUM_STATES);
                        cnt_d   = MW'(k);
                        state_d = (k == 0) ? S_DWELL : S_STEP;
                    end
                end
            end
            S_STEP: begin
                // Downstream advances on this same edge; keep the mirror in lockstep.
                mirror_d = (mirror_q == MW'(NUM_STATES - 1)) ?
                           '0 : mirror_q + MW'(1);
                if (cnt_q == MW'(1)) begin
                    state_d = S_DWELL;
                end else begin
                    cnt_d = cnt_q - MW'(1);
                end
            end
            S_DWELL: begin
                state_d = S_CAPTURE;
            end
            S_CAPTURE: begin
                rsp_d   = signal_in;
                state_d = S_RESP;
            end
            S_RESP: begin
                if (rsp_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign rdy_d = (state_d == S_IDLE);

    always_comb begin
        req_ready = rdy_q;
        signal    = (state_q == S_STEP) ? WIDTH'(STEP_CODE) : '0;
        next      = (state_q == S_DWELL);
        data_out  = (state_q == S_DWELL) ? data_q : '0;
        rsp_valid = (state_q == S_RESP);
        rsp_data  = rsp_q;
    end

endmodule

// File: tb/tb_acc_fsm_sequencer.sv
// Bench for acc_fsm_sequencer with a paired accumulator model.
// Expected responses come from an op-level model of the accumulator.
module tb_acc_fsm_sequencer;

    localparam int W = 16;
    localparam logic [W-1:0] SC = 16'h0001;

    logic         clk = 1'b0;
    logic         rst;
    logic         req_valid;
    logic         req_ready;
    logic [1:0]   req_op;
    logic [W-1:0] req_data;
    logic [W-1:0] signal;
    logic         next;
    logic [W-1:0] data_out;
    logic [W-1:0] signal_in;
    logic         rsp_valid;
    logic         rsp_ready;
    logic [W-1:0] rsp_data;

    int checks = 0;
    int errors = 0;

    // op-level reference: current downstream state and held value in ADD state
    int           m;
    logic [W-1:0] a_val;

    always #5 clk = ~clk;

    acc_fsm_sequencer #(
        .WIDTH(W),
        .NUM_STATES(3),
        .STEP_CODE(1)
    ) dut (
        .clk(clk),
        .rst(rst),
        .req_valid(req_valid),
        .req_ready(req_ready),
        .req_op(req_op),
        .req_data(req_data),
        .signal(signal),
        .next(next),
        .data_out(data_out),
        .signal_in(signal_in),
        .rsp_valid(rsp_valid),
        .rsp_ready(rsp_ready),
        .rsp_data(rsp_data)
    );

    // downstream accumulator: 0=clear, 1=add, 2=load; steps on SC
    logic [1:0]   dst;
    logic [W-1:0] dacc;
    assign signal_in = dacc;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dst  <= 2'd0;
            dacc <= '0;
        end else begin
            case (dst)
                2'd0:    dacc <= '0;
                2'd1:    dacc <= dacc + data_out;
                default: dacc <= data_out;
            endcase
            if (signal == SC) dst <= (dst == 2'd2) ? 2'd0 : dst + 2'd1;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_idle_outs(input string tag);
        chk({tag, "_signal"}, signal, 0);
        chk({tag, "_next"}, next, 0);
        chk({tag, "_data_out"}, data_out, 0);
    endtask

    task automatic do_op(input int op, input logic [W-1:0] d, input int hold);
        int t, k, lat, nstep, nnext, c;
        logic [W-1:0] exp;
        bit done;
        if (op == 3) begin
            t   = m;
            k   = 0;
            lat = 2;
            exp = (m == 1) ? a_val : '0;
        end else begin
            t   = op;
            k   = (t - m + 3) % 3;
            lat = k + 3;
            case (op)
                0:       exp = '0;
                1:       exp = (m == 1) ? a_val + d : d;
                default: exp = d;
            endcase
        end
        c = 0;
        while (!req_ready && c < 20) begin
            @(negedge clk);
            c++;
        end
        chk("req_ready_wait", req_ready, 1);
        req_valid = 1'b1;
        req_op    = 2'(op);
        req_data  = d;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        req_op    = 2'd0;
        req_data  = '0;
        nstep = 0;
        nnext = 0;
        c     = 0;
        done  = 0;
        while (!done && c < 20) begin
            @(negedge clk);
            c++;
            chk("signal_legal", (signal == '0) || (signal == SC), 1);
            chk("ready_busy", req_ready, 0);
            if (signal == SC) nstep++;
            if (next) begin
                nnext++;
                chk("dwell_data", data_out, d);
            end
            if (rsp_valid) done = 1;
        end
        chk("rsp_latency", c, lat);
        chk("step_count", nstep, k);
        chk("next_count", nnext, (op == 3) ? 0 : 1);
        chk("rsp_data", rsp_data, exp);
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            chk("hold_valid", rsp_valid, 1);
            chk("hold_data", rsp_data, exp);
            chk("hold_ready", req_ready, 0);
            chk_idle_outs("hold");
        end
        rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        rsp_ready = 1'b0;
        @(negedge clk);
        chk("ready_after_hs", req_ready, 1);
        chk("valid_after_hs", rsp_valid, 0);
        if (op != 3) m = t;
        a_val = exp;
    endtask

    initial begin
        rst       = 1'b1;
        req_valid = 1'b0;
        req_op    = 2'd0;
        req_data  = '0;
        rsp_ready = 1'b0;
        m         = 0;
        a_val     = '0;
        repeat (2) @(negedge clk);
        chk("rst_req_ready", req_ready, 0);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_rsp_data", rsp_data, 0);
        chk_idle_outs("rst");
        rst = 1'b0;
        @(negedge clk);
        chk("ready_after_reset", req_ready, 1);

        // directed sequence
        do_op(2, 16'h0005, 0);
        do_op(1, 16'h0003, 0);
        do_op(1, 16'h0004, 5);
        do_op(0, 16'h00aa, 0);
        do_op(3, 16'h0000, 0);

        // abort a LOAD while it is stepping
        while (!req_ready) @(negedge clk);
        req_valid = 1'b1;
        req_op    = 2'd2;
        req_data  = 16'h1234;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        req_data  = '0;
        @(negedge clk);
        chk("abort_pre_step", signal, SC);
        rst = 1'b1;
        #1;
        chk("abort_signal", signal, 0);
        chk("abort_next", next, 0);
        chk("abort_data_out", data_out, 0);
        chk("abort_req_ready", req_ready, 0);
        chk("abort_rsp_valid", rsp_valid, 0);
        chk("abort_rsp_data", rsp_data, 0);
        @(negedge clk);
        rst = 1'b0;
        m     = 0;
        a_val = '0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk("abort_no_rsp", rsp_valid, 0);
        end
        do_op(2, 16'h0009, 0);

        // random ops against the op-level model
        for (int i = 0; i < 40; i++) begin
            do_op(int'($urandom_range(0, 3)), 16'($urandom),
                  int'($urandom_range(0, 3)));
        end
        do_op(1, 16'hffff, 1);
        do_op(1, 16'h0002, 0);
        do_op(3, 16'h0000, 2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
